// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: diff = a - b - borrow_in, LSB first.
// One full-adder cell iterated over shift registers, valid/ready on both sides.
module serial_subtractor #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         borrow_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         borrow_out,
    output logic         overflow,
    output logic         zero
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [N-1:0]  a_sh, b_sh, diff_sh;
    logic [N-1:0]  diff_nx;
    logic [CW-1:0] count;
    logic          carry, carry_nx, s;
    logic          sa, sb;
    logic          last;

    assign in_ready = (state == IDLE) && !rst;

    // a - b - bin == a + ~b + ~bin, so the adder sees ~b and ~borrow_in
    always_comb begin
        s        = a_sh[0] ^ b_sh[0] ^ carry;
        carry_nx = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
        diff_nx  = {s, diff_sh[N-1:1]};
        last     = (count == LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (in_valid && in_ready) state_nx = BUSY;
            BUSY: if (last) state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh       <= '0;
            b_sh       <= '0;
            diff_sh    <= '0;
            count      <= '0;
            carry      <= 1'b0;
            sa         <= 1'b0;
            sb         <= 1'b0;
            out_valid  <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
            zero       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sh  <= a;
                        b_sh  <= ~b;
                        carry <= ~borrow_in;
                        count <= '0;
                        sa    <= a[N-1];
                        sb    <= b[N-1];
                    end
                end
                BUSY: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    carry   <= carry_nx;
                    diff_sh <= diff_nx;
                    count   <= count + CW'(1);
                    if (last) begin
                        out_valid  <= 1'b1;
                        diff       <= diff_nx;
                        borrow_out <= ~carry_nx;
                        overflow   <= (sa != sb) && (s != sa);
                        zero       <= (diff_nx == '0);
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
